// File: rtl/vga_pixel_fetch_pkg.sv
// Shared constants for the VGA pixel fetch path: frame geometry, pixel format
// and fetch FSM encodings.
package vga_pixel_fetch_pkg;

   localparam int HDISPLAY      = 640;
   localparam int VDISPLAY      = 480;
   localparam int FB_PIXELS_DEF = HDISPLAY * VDISPLAY;
   localparam int FB_BASE_DEF   = 0;
   localparam int PIXEL_W       = 8;

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_REQ  = 1'b1;

endpackage

// File: rtl/vga_pixel_fetch_pixel_fifo.sv
// Show-ahead synchronous FIFO used to buffer prefetched pixels.
// A flush empties it in one cycle and takes priority over push and pop.
module pixel_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_pop  = pop && (count != '0) && !flush;
   assign do_push = push && (count != CW'(DEPTH)) && !flush;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)
            rd_ptr <= rd_ptr + AW'(1);
         unique case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage carries no reset; only the pointers and count define validity.
   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/vga_pixel_fetch.sv
// Prefetches framebuffer pixels over a single-outstanding req/ack port and
// streams them out during active video, pausing the timing generator when dry.
module vga_pixel_fetch
   import vga_pixel_fetch_pkg::*;
#(
   parameter int ADDR_W     = 18,
   parameter int DATA_W     = PIXEL_W,
   parameter int FIFO_DEPTH = 16,
   parameter int FB_BASE    = FB_BASE_DEF,
   parameter int FB_PIXELS  = FB_PIXELS_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              vs,
   input  logic              blank,
   output logic              hold,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [DATA_W-1:0] rgb,
   output logic              underflow
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [ADDR_W-1:0] ADDR_FIRST = ADDR_W'(FB_BASE);
   localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(FB_BASE + FB_PIXELS - 1);

   logic [0:0]        state;
   logic              discard;
   logic              vs_d;
   logic [CW-1:0]     count;
   logic [CW-1:0]     occupancy;
   logic [DATA_W-1:0] head;
   logic              flush;
   logic              pop;
   logic              push;
   logic              issue;

   function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
      return (a == ADDR_LAST) ? ADDR_FIRST : a + ADDR_W'(1);
   endfunction

   assign flush     = vs_d && !vs;
   assign pop       = !blank && (count != '0);
   assign push      = (state == S_REQ) && mem_ack && !discard && !flush;
   // An outstanding request already owns a FIFO slot.
   assign occupancy = count + CW'(state == S_REQ);
   assign issue     = (state == S_IDLE) && (occupancy < CW'(FIFO_DEPTH)) && !flush;

   assign mem_req = (state == S_REQ);
   assign hold    = (count == '0);
   assign rgb     = blank ? '0 : head;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         mem_addr  <= ADDR_FIRST;
         discard   <= 1'b0;
         vs_d      <= 1'b1;
         underflow <= 1'b0;
      end else begin
         vs_d <= vs;
         if (!blank && (count == '0))
            underflow <= 1'b1;
         unique case (state)
            S_IDLE: begin
               if (flush)
                  mem_addr <= ADDR_FIRST;
               else if (issue)
                  state <= S_REQ;
            end
            S_REQ: begin
               if (mem_ack) begin
                  state   <= S_IDLE;
                  discard <= 1'b0;
                  // Address restart is deferred to the ack so mem_addr never
                  // moves under an outstanding request.
                  if (flush || discard)
                     mem_addr <= ADDR_FIRST;
                  else
                     mem_addr <= next_addr(mem_addr);
               end else if (flush) begin
                  discard <= 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   pixel_fifo #(
      .WIDTH (DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .flush (flush),
      .din   (mem_rdata),
      .dout  (head),
      .count (count)
   );

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Randomised bench for vga_pixel_fetch with a queue-based frame/FIFO reference
// model and a latency-programmable memory responder.
module tb_vga_pixel_fetch;

   localparam int FBP   = 300;
   localparam int DEPTH = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic        vs;
   logic        raw_blank;
   logic        gate;
   logic        blank;
   logic        hold;
   logic        mem_req;
   logic [17:0] mem_addr;
   logic        mem_ack;
   logic [7:0]  mem_rdata;
   logic [7:0]  rgb;
   logic        underflow;

   always #5 clk = ~clk;

   // Stand-in for the timing generator: while held it shows blank.
   assign blank = raw_blank | (gate & hold);

   vga_pixel_fetch #(
      .ADDR_W     (18),
      .DATA_W     (8),
      .FIFO_DEPTH (DEPTH),
      .FB_BASE    (0),
      .FB_PIXELS  (FBP)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .vs        (vs),
      .blank     (blank),
      .hold      (hold),
      .mem_req   (mem_req),
      .mem_addr  (mem_addr),
      .mem_ack   (mem_ack),
      .mem_rdata (mem_rdata),
      .rgb       (rgb),
      .underflow (underflow)
   );

   int checks   = 0;
   int failures = 0;

   int          q[$];
   int          req_log[$];
   int          exp_addr;
   bit          req_flushed;
   bit          vs_prev;
   bit          uf;
   bit          exp_req;
   bit          prev_req;
   logic [17:0] prev_addr;
   bit          last_pop;
   int          last_rgb;
   bit          vs_nxt    = 1'b1;
   bit          blank_nxt = 1'b1;
   bit          rand_lat  = 1'b0;
   bit          rand_blank = 1'b0;
   bit          rand_vs   = 1'b0;
   int          lat_max   = 1;
   int          cur_lat;
   int          wcnt;

   task automatic model_reset();
      q.delete();
      exp_addr    = 0;
      req_flushed = 1'b0;
      vs_prev     = 1'b1;
      uf          = 1'b0;
      exp_req     = 1'b0;
      prev_req    = 1'b0;
      prev_addr   = '0;
      wcnt        = 0;
      cur_lat     = lat_max;
   endtask

   // One pixel clock: drive inputs at the falling edge, compare against the
   // model, advance the model to what the next rising edge should produce.
   task automatic step();
      int sz;
      bit flush;
      bit ack;
      bit kept;
      bit pop;
      vs        = rand_vs ? ($urandom_range(0, 49) != 0) : vs_nxt;
      raw_blank = rand_blank ? ($urandom_range(0, 3) == 0) : blank_nxt;
      if (!mem_req) begin
         wcnt      = 0;
         cur_lat   = rand_lat ? int'($urandom_range(0, lat_max)) : lat_max;
         mem_ack   = 1'b0;
         mem_rdata = 8'($urandom);
      end else if (wcnt >= cur_lat) begin
         mem_ack   = 1'b1;
         mem_rdata = mem_addr[7:0];
      end else begin
         mem_ack   = 1'b0;
         mem_rdata = 8'($urandom);
         wcnt++;
      end
      #1;
      sz = q.size();
      checks++;
      if (hold !== (sz == 0)) begin
         failures++;
         $display("FAIL hold got=%0b want=%0b t=%0t", hold, (sz == 0), $time);
      end
      checks++;
      if (underflow !== uf) begin
         failures++;
         $display("FAIL underflow got=%0b want=%0b t=%0t", underflow, uf, $time);
      end
      if (blank) begin
         checks++;
         if (rgb !== 8'h00) begin
            failures++;
            $display("FAIL rgb_blank got=%0d want=0 t=%0t", rgb, $time);
         end
      end else if (sz > 0) begin
         checks++;
         if (rgb !== 8'(q[0])) begin
            failures++;
            $display("FAIL rgb_pixel got=%0d want=%0d t=%0t", rgb, q[0], $time);
         end
      end
      checks++;
      if (mem_req !== exp_req) begin
         failures++;
         $display("FAIL mem_req got=%0b want=%0b t=%0t", mem_req, exp_req, $time);
      end
      if (mem_req && !prev_req) begin
         req_log.push_back(int'(mem_addr));
         checks++;
         if (mem_addr !== 18'(exp_addr)) begin
            failures++;
            $display("FAIL req_addr got=%0d want=%0d t=%0t", mem_addr, exp_addr, $time);
         end
      end else if (mem_req && prev_req) begin
         checks++;
         if (mem_addr !== prev_addr) begin
            failures++;
            $display("FAIL addr_stable got=%0d want=%0d t=%0t", mem_addr, prev_addr, $time);
         end
      end
      checks++;
      if (sz + (mem_req ? 1 : 0) > DEPTH) begin
         failures++;
         $display("FAIL overissue got=%0d want<=%0d t=%0t", sz + 1, DEPTH, $time);
      end

      flush    = vs_prev && !vs;
      ack      = mem_req && mem_ack;
      pop      = !blank && (sz > 0);
      last_pop = pop;
      last_rgb = int'(rgb);
      exp_req  = mem_req ? !ack : ((sz < DEPTH) && !flush);
      if (!blank && sz == 0)
         uf = 1'b1;
      kept = ack && !flush && !req_flushed;
      if (flush) begin
         q.delete();
         exp_addr    = 0;
         req_flushed = mem_req && !ack;
      end else begin
         if (pop)
            void'(q.pop_front());
         if (kept) begin
            q.push_back(exp_addr % 256);
            exp_addr = (exp_addr == FBP - 1) ? 0 : exp_addr + 1;
         end
         if (ack)
            req_flushed = 1'b0;
      end
      checks++;
      if (q.size() > DEPTH) begin
         failures++;
         $display("FAIL push_full got=%0d want<=%0d t=%0t", q.size(), DEPTH, $time);
      end
      vs_prev   = vs;
      prev_req  = mem_req;
      prev_addr = mem_addr;
      @(negedge clk);
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if (hold !== 1'b1) begin failures++; $display("FAIL reset_hold got=%0b want=1", hold); end
      checks++;
      if (mem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%0b want=0", mem_req); end
      checks++;
      if (mem_addr !== 18'd0) begin failures++; $display("FAIL reset_addr got=%0d want=0", mem_addr); end
      checks++;
      if (underflow !== 1'b0) begin failures++; $display("FAIL reset_uf got=%0b want=0", underflow); end
      checks++;
      if (rgb !== 8'd0) begin failures++; $display("FAIL reset_rgb got=%0d want=0", rgb); end
      @(negedge clk);
      reset = 1'b0;
      model_reset();
   endtask

   task automatic test_fill();
      lat_max   = 1;
      blank_nxt = 1'b1;
      req_log.delete();
      repeat (80) step();
      checks++;
      if (req_log.size() != 16) begin
         failures++;
         $display("FAIL fill_count got=%0d want=16", req_log.size());
      end
      for (int i = 0; i < req_log.size(); i++) begin
         checks++;
         if (req_log[i] != i) begin
            failures++;
            $display("FAIL fill_addr got=%0d want=%0d", req_log[i], i);
         end
      end
      checks++;
      if (hold !== 1'b0) begin failures++; $display("FAIL fill_hold got=%0b want=0", hold); end
      for (int i = 0; i < 5; i++) begin
         step();
         checks++;
         if (mem_req !== 1'b0) begin failures++; $display("FAIL full_req got=%0b want=0", mem_req); end
      end
   endtask

   task automatic test_pop8();
      req_log.delete();
      blank_nxt = 1'b0;
      for (int i = 0; i < 8; i++) begin
         step();
         checks++;
         if (!last_pop || last_rgb != i) begin
            failures++;
            $display("FAIL pop8 got=%0d(pop=%0b) want=%0d", last_rgb, last_pop, i);
         end
      end
      blank_nxt = 1'b1;
      repeat (30) step();
      checks++;
      if (req_log.size() == 0 || req_log[0] != 16) begin
         failures++;
         $display("FAIL refill_start got=%0d want=16", (req_log.size() > 0) ? req_log[0] : -1);
      end
      checks++;
      if (underflow !== 1'b0) begin failures++; $display("FAIL pop8_uf got=%0b want=0", underflow); end
   endtask

   task automatic test_flush_outstanding();
      bit found = 1'b0;
      lat_max   = 3;
      blank_nxt = 1'b0;
      for (int i = 0; i < 2000 && !found; i++) begin
         step();
         if (mem_req && mem_addr == 18'd40) found = 1'b1;
      end
      checks++;
      if (!found) begin
         failures++;
         $display("FAIL reach_addr40 got=timeout want=req@40");
      end else begin
         vs_nxt = 1'b0;
         step();
         checks++;
         if (hold !== 1'b1) begin failures++; $display("FAIL flush_count got=hold%0b want=hold1", hold); end
         vs_nxt = 1'b1;
         req_log.delete();
         for (int i = 0; i < 200 && req_log.size() == 0; i++) step();
         checks++;
         if (req_log.size() == 0 || req_log[0] != 0) begin
            failures++;
            $display("FAIL flush_next_addr got=%0d want=0", (req_log.size() > 0) ? req_log[0] : -1);
         end
         last_pop = 1'b0;
         for (int i = 0; i < 200 && !last_pop; i++) step();
         checks++;
         if (!last_pop || last_rgb != 0) begin
            failures++;
            $display("FAIL flush_first_pixel got=%0d(pop=%0b) want=0", last_rgb, last_pop);
         end
      end
   endtask

   task automatic test_drain();
      int prev  = -1;
      int bad   = 0;
      int pops  = 0;
      int holds = 0;
      lat_max   = 5;
      blank_nxt = 1'b0;
      repeat (300) begin
         step();
         if (hold) holds++;
         if (last_pop) begin
            if (prev >= 0 && last_rgb != (prev + 1) % 256) bad++;
            prev = last_rgb;
            pops++;
         end
      end
      checks++;
      if (bad != 0) begin failures++; $display("FAIL drain_contig got=%0d want=0", bad); end
      checks++;
      if (pops < 20 || holds == 0) begin
         failures++;
         $display("FAIL drain_activity got=pops%0d,holds%0d want=pops>=20,holds>0", pops, holds);
      end
      checks++;
      if (underflow !== 1'b0) begin failures++; $display("FAIL drain_uf got=%0b want=0", underflow); end
   endtask

   task automatic test_random();
      rand_lat   = 1'b1;
      rand_blank = 1'b1;
      rand_vs    = 1'b1;
      lat_max    = 4;
      repeat (800) step();
      rand_lat   = 1'b0;
      rand_blank = 1'b0;
      rand_vs    = 1'b0;
      vs_nxt     = 1'b1;
      checks++;
      if (underflow !== 1'b0) begin failures++; $display("FAIL random_uf got=%0b want=0", underflow); end
   endtask

   task automatic test_wrap();
      bit found = 1'b0;
      lat_max   = 0;
      blank_nxt = 1'b0;
      for (int i = 0; i < 3000 && !found; i++) begin
         step();
         if (mem_req && mem_addr == 18'(FBP - 1)) found = 1'b1;
      end
      checks++;
      if (!found) begin
         failures++;
         $display("FAIL reach_last got=timeout want=req@%0d", FBP - 1);
      end else begin
         req_log.delete();
         for (int i = 0; i < 50 && req_log.size() < 2; i++) step();
         checks++;
         if (req_log.size() < 2 || req_log[0] != FBP - 1 || req_log[1] != 0) begin
            failures++;
            $display("FAIL wrap got=%0d,%0d want=%0d,0", (req_log.size() > 0) ? req_log[0] : -1,
                     (req_log.size() > 1) ? req_log[1] : -1, FBP - 1);
         end
      end
   endtask

   task automatic test_vs_long();
      lat_max   = 1;
      blank_nxt = 1'b1;
      repeat (80) step();
      req_log.delete();
      vs_nxt = 1'b0;
      repeat (10) step();
      vs_nxt = 1'b1;
      checks++;
      if (req_log.size() < 2) begin failures++; $display("FAIL vslong_refill got=%0d want>=2", req_log.size()); end
      repeat (60) step();
      checks++;
      if (req_log.size() != 16) begin failures++; $display("FAIL vslong_count got=%0d want=16", req_log.size()); end
      for (int i = 0; i < req_log.size(); i++) begin
         checks++;
         if (req_log[i] != i) begin
            failures++;
            $display("FAIL vslong_addr got=%0d want=%0d", req_log[i], i);
         end
      end
      checks++;
      if (hold !== 1'b0) begin failures++; $display("FAIL vslong_hold got=%0b want=0", hold); end
   endtask

   task automatic test_reset_mid();
      bit found = 1'b0;
      lat_max = 5;
      vs_nxt  = 1'b0;
      step();
      vs_nxt = 1'b1;
      for (int i = 0; i < 20 && !found; i++) begin
         step();
         if (mem_req) found = 1'b1;
      end
      checks++;
      if (!found) begin failures++; $display("FAIL midreq_wait got=timeout want=mem_req"); end
      reset   = 1'b1;
      mem_ack = 1'b0;
      #1;
      checks++;
      if (mem_req !== 1'b0) begin failures++; $display("FAIL midreset_req got=%0b want=0", mem_req); end
      checks++;
      if (hold !== 1'b1) begin failures++; $display("FAIL midreset_hold got=%0b want=1", hold); end
      checks++;
      if (mem_addr !== 18'd0) begin failures++; $display("FAIL midreset_addr got=%0d want=0", mem_addr); end
      repeat (2) @(negedge clk);
      reset   = 1'b0;
      lat_max = 1;
      model_reset();
      req_log.delete();
      repeat (40) step();
      checks++;
      if (req_log.size() == 0 || req_log[0] != 0) begin
         failures++;
         $display("FAIL midreset_restart got=%0d want=0", (req_log.size() > 0) ? req_log[0] : -1);
      end
   endtask

   task automatic test_underflow();
      gate      = 1'b0;
      blank_nxt = 1'b0;
      vs_nxt    = 1'b0;
      step();
      vs_nxt = 1'b1;
      repeat (5) step();
      checks++;
      if (underflow !== 1'b1) begin failures++; $display("FAIL uf_set got=%0b want=1", underflow); end
      blank_nxt = 1'b1;
      repeat (40) step();
      checks++;
      if (underflow !== 1'b1) begin failures++; $display("FAIL uf_sticky got=%0b want=1", underflow); end
      reset = 1'b1;
      #1;
      checks++;
      if (underflow !== 1'b0) begin failures++; $display("FAIL uf_reset got=%0b want=0", underflow); end
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      reset     = 1'b1;
      vs        = 1'b1;
      raw_blank = 1'b1;
      gate      = 1'b1;
      mem_ack   = 1'b0;
      mem_rdata = 8'd0;
      model_reset();
      test_reset();
      test_fill();
      test_pop8();
      test_flush_outstanding();
      test_drain();
      test_random();
      test_wrap();
      test_vs_long();
      test_reset_mid();
      test_underflow();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
